hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
// - Producer side of the EX-stage operand-forwarding path: generates FselA/FselB for the A/B forwarding muxes (00 = regfile/imm
//   operand, 01 = ALU_OUT_rg3 from EX/MEM, 10 = final_mux_out from WB), plus load-use stall and branch-flush controls.
// - Keeps its own shadow pipe of destination info (EX->MEM->WB); feeds saturating stall/flush counters to the pipeline tracer.
// PARAMETERS
// - LOAD_STALL  1   bubble cycles inserted for a load-use hazard (1..3)
// - CNT_W       16  width of the stall/flush event counters
// PORTS
// - clk             in   1      clock; all state updates on rising edge
// - rst             in   1      synchronous reset, active-high
// - rs1_d, rs2_d    in   5      source regs of instruction in DECODE
// - use_rs1_d/rs2_d in   1      decode instruction actually reads rs1/rs2
// - rs1_e, rs2_e    in   5      source regs of instruction in EXECUTE
// - rd_e            in   5      destination reg of instruction in EXECUTE
// - reg_wr_e        in   1      EX instruction writes regfile
// - is_load_e       in   1      EX instruction is a load
// - br_taken_e      in   1      branch/jump resolved taken in EX this cycle
// - FselA, FselB    out  2      forward selects for operand A / B
// - stall_f, stall_d out 1      hold PC / IF-ID register
// - flush_d, flush_e out 1      bubble IF-ID / ID-EX register
// - stall_cnt, flush_cnt out CNT_W  saturating event counters
// BEHAVIOUR
// - Shadow pipe, every cycle (no enable): rd_m<=rd_e, wr_m<=reg_wr_e, ld_m<=is_load_e; rd_w<=rd_m, wr_w<=wr_m.
//   EX->MEM always advances: bubbles are injected into EX, never MEM, so the shadow needs no stall gating.
// - Forward select (combinational from shadow regs + rs*_e), per operand, priority high->low:
//   wr_m && rd_m!=0 && rd_m==rsX_e && !ld_m -> 2'b01; wr_w && rd_w!=0 && rd_w==rsX_e -> 2'b10; else 2'b00.
//   Register x0 never forwarded. 2'b11 never driven.
// - Load-use detect: lu = is_load_e && reg_wr_e && rd_e!=0 && ((use_rs1_d && rs1_d==rd_e)||(use_rs2_d && rs2_d==rd_e)).
// - Stall FSM: IDLE / STALL with counter scnt (2 bit).
//   IDLE: lu && !br_taken_e -> stall_f=stall_d=flush_e=1 this cycle; if LOAD_STALL>1 go STALL, scnt=LOAD_STALL-1.
//   STALL: stall_f=stall_d=flush_e=1; scnt-- each cycle; scnt==1 -> IDLE next cycle. lu is not re-evaluated in STALL.
//   Total stall = LOAD_STALL cycles per hazard; the dependent instruction enters EX with the load in WB -> FselX=10 (LOAD_STALL=1).
// - Flush: br_taken_e -> flush_d=flush_e=1 same cycle (combinational); stall_f=stall_d=0.
//   Branch wins over load-use: flush suppresses stall and forces FSM to IDLE, scnt=0.
// - Counters: stall_cnt += 1 each cycle stall_d=1; flush_cnt += 1 each cycle br_taken_e=1.
//   Both saturate at all-ones; no wrap.
// - Reset (rst=1 at edge): rd_m/rd_w=0, wr_m/wr_w/ld_m=0, FSM=IDLE, scnt=0, counters=0.
//   Resulting outputs: FselA=FselB=00, all stall/flush=0, unless the comb inputs assert lu/br_taken_e.
//   Reset mid-stall aborts the stall; the next cycle re-evaluates lu from scratch.
// - Latency: selects, stall, flush are same-cycle combinational; counters update one cycle after the event.
// STRUCTURE
// - Shared package hazard_pkg: typedef enum logic[1:0] fwd_sel_t {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_WB=2'b10};
//   typedef enum logic {HZ_IDLE, HZ_STALL} hz_state_t; localparam REG_X0 = 5'd0.
//   Forward-mux modules use fwd_sel_t as their select type.
// - One sub-module: fwd_sel_logic (per-operand priority compare), instantiated twice for A and B; FSM and counters inline.
// TESTING
// - EX/MEM hit: cycle n rd_e=5,reg_wr_e=1; cycle n+1 rs2_e=5 -> FselB=01, FselA=00 (rs1_e=6).
// - Double hit: rd_m=7 and rd_w=7 both writing, rs1_e=7 -> FselA=01; rd_m=0 writing, rd_w=0, rs1_e=0 -> FselA=00.
// - Load-use, LOAD_STALL=1: is_load_e,rd_e=9, rs1_d=9,use_rs1_d -> 1 cycle stall_f=stall_d=flush_e=1;
//   two cycles later rs1_e=9 -> FselA=10; stall_cnt=1.
// - LOAD_STALL=3 same stimulus -> stall high exactly 3 consecutive cycles; stall_cnt=3.
// - Branch + load-use same cycle: br_taken_e=1, lu=1 -> flush_d=flush_e=1, stall_d=0, FSM IDLE; flush_cnt=1.
// - rst asserted during 2nd cycle of a 3-cycle stall -> next cycle stall=0, Fsel=00, counters=0;
//   also force stall_cnt to all-ones and stall again -> holds at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the EX-stage forwarding and hazard control.
// Forward-select encoding, stall FSM states, and a source-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_WB    = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_IDLE,
        HZ_STALL
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when a writing producer targets a non-x0 register equal to rs.
    function automatic logic src_hit(
        input logic [4:0] rd,
        input logic       wr,
        input logic [4:0] rs
    );
        return wr && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Per-operand forward select: EX/MEM result beats WB result beats regfile.
// Loads in MEM have no data yet, so they never drive the EX/MEM path.
module fwd_sel_logic
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       wr_m,
    input  logic       ld_m,
    input  logic [4:0] rd_w,
    input  logic       wr_w,
    output fwd_sel_t   fsel
);

    // Priority compare against the MEM then WB shadow destinations.
    always_comb begin
        fsel = FWD_RF;
        if (src_hit(rd_m, wr_m, rs) && !ld_m) begin
            fsel = FWD_EXMEM;
        end else if (src_hit(rd_w, wr_w, rs)) begin
            fsel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding selects, load-use stall FSM and branch flush for the EX stage.
// Tracks destination info through MEM/WB and counts stall/flush events.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             reg_wr_e,
    input  logic             is_load_e,
    input  logic             br_taken_e,
    output logic [1:0]       FselA,
    output logic [1:0]       FselB,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic       wr_m;
    logic       wr_w;
    logic       ld_m;

    fwd_sel_t   sel_a;
    fwd_sel_t   sel_b;

    hz_state_t  state;
    hz_state_t  state_nx;
    logic [1:0] scnt;
    logic [1:0] scnt_nx;
    logic       lu;
    logic       stall;

    // Shadow of the EX destination as it moves through MEM and WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_m <= REG_X0;
            rd_w <= REG_X0;
            wr_m <= 1'b0;
            wr_w <= 1'b0;
            ld_m <= 1'b0;
        end else begin
            rd_m <= rd_e;
            wr_m <= reg_wr_e;
            ld_m <= is_load_e;
            rd_w <= rd_m;
            wr_w <= wr_m;
        end
    end

    fwd_sel_logic u_fwd_a (
        .rs   (rs1_e),
        .rd_m (rd_m),
        .wr_m (wr_m),
        .ld_m (ld_m),
        .rd_w (rd_w),
        .wr_w (wr_w),
        .fsel (sel_a)
    );

    fwd_sel_logic u_fwd_b (
        .rs   (rs2_e),
        .rd_m (rd_m),
        .wr_m (wr_m),
        .ld_m (ld_m),
        .rd_w (rd_w),
        .wr_w (wr_w),
        .fsel (sel_b)
    );

    assign FselA = sel_a;
    assign FselB = sel_b;

    // Decode-stage consumer needs a load result still sitting in EX.
    always_comb begin
        lu = 1'b0;
        if (is_load_e && reg_wr_e && (rd_e != REG_X0)) begin
            lu = (use_rs1_d && (rs1_d == rd_e)) ||
                 (use_rs2_d && (rs2_d == rd_e));
        end
    end

    // Stall/flush decisions; a taken branch overrides any pending stall.
    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        stall    = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (br_taken_e) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            state_nx = HZ_IDLE;
            scnt_nx  = 2'd0;
        end else begin
            unique case (state)
                HZ_IDLE: begin
                    if (lu) begin
                        stall   = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nx = HZ_STALL;
                            scnt_nx  = STALL_INIT;
                        end
                    end
                end
                HZ_STALL: begin
                    stall   = 1'b1;
                    flush_e = 1'b1;
                    scnt_nx = scnt - 2'd1;
                    if (scnt == 2'd1) begin
                        state_nx = HZ_IDLE;
                    end
                end
                default: begin
                    state_nx = HZ_IDLE;
                    scnt_nx  = 2'd0;
                end
            endcase
        end
    end

    assign stall_f = stall;
    assign stall_d = stall;

    // Stall FSM state and remaining-bubble count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_IDLE;
            scnt  <= 2'd0;
        end else begin
            state <= state_nx;
            scnt  <= scnt_nx;
        end
    end

    // Saturating event counters for the pipeline tracer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_taken_e && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
